// File: rtl/basys3_keypad_pkg.sv
// basys3_keypad_pkg
//   Shared definitions for the 4x4 keypad scanner: FSM state type, default
//   timing constants, the key-map table and small lookup helpers.
package basys3_keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam int unsigned DEF_SETTLE_CYCLES   = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 20;

    // Nibble index = {row, col}; nibble 0 is row 0 / column 0.
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

    // Index of the lowest-numbered active-low row (caller guarantees one is low).
    function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
        if (!rows_n[0])      return 2'd0;
        else if (!rows_n[1]) return 2'd1;
        else if (!rows_n[2]) return 2'd2;
        else                 return 2'd3;
    endfunction

endpackage

// File: rtl/basys3_sync2.sv
// basys3_sync2
//   Two-flop synchronizer for asynchronous inputs.
//   Ports:
//     i_clk   - destination clock
//     i_rst   - synchronous active-high reset, loads RESET_VAL
//     i_d     - asynchronous input bus
//     o_q     - synchronized output bus
module basys3_sync2 #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/basys3_keypad_scanner.sv
// basys3_keypad_scanner
//   Scans a 4x4 active-low keypad matrix one column at a time, debounces a
//   press on the latched row/column and reports the key code.
//   Ports:
//     clk_1k_i      - scan clock, all state on rising edge
//     rst_i         - synchronous active-high reset
//     row_ni[3:0]   - asynchronous row lines, active-low
//     col_no[3:0]   - column drive, active-low one-hot
//     key_o[3:0]    - hex code of the last accepted key
//     key_valid_o   - one-cycle pulse on accepted press
//     key_held_o    - high while the accepted key stays pressed
//     key_release_o - one-cycle pulse on accepted release
//   Build option: BASYS3_KEYPAD_RELEASE_EN enables key_release_o; when not
//   defined the output is tied low and release still returns to scanning.
module basys3_keypad_scanner
    import basys3_keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk_1k_i,
    input  logic       rst_i,
    input  logic [3:0] row_ni,
    output logic [3:0] col_no,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       key_held_o,
    output logic       key_release_o
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX     = '1;

    logic [3:0]    w_rows;
    logic          w_row_low;

    state_t        r_state,  w_state;
    logic [1:0]    r_col,    w_col;
    logic [1:0]    r_row,    w_row;
    logic [SW-1:0] r_settle, w_settle;
    logic [DW-1:0] r_deb,    w_deb;
    logic [3:0]    r_key,    w_key;
    logic          r_valid,  w_valid;
    logic          r_held,   w_held;

    basys3_sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .i_clk (clk_1k_i),
        .i_rst (rst_i),
        .i_d   (row_ni),
        .o_q   (w_rows)
    );

    assign w_row_low = ~w_rows[r_row];

`ifdef BASYS3_KEYPAD_RELEASE_EN
    logic r_release, w_release;
`endif

    always_ff @(posedge clk_1k_i) begin
        if (rst_i) begin
            r_state  <= ST_SCAN;
            r_col    <= '0;
            r_row    <= '0;
            r_settle <= '0;
            r_deb    <= '0;
            r_key    <= '0;
            r_valid  <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_col    <= w_col;
            r_row    <= w_row;
            r_settle <= w_settle;
            r_deb    <= w_deb;
            r_key    <= w_key;
            r_valid  <= w_valid;
            r_held   <= w_held;
        end
    end

`ifdef BASYS3_KEYPAD_RELEASE_EN
    always_ff @(posedge clk_1k_i) begin
        if (rst_i) r_release <= 1'b0;
        else       r_release <= w_release;
    end
`endif

    always_comb begin
        w_state  = r_state;
        w_col    = r_col;
        w_row    = r_row;
        w_settle = r_settle;
        w_deb    = r_deb;
        w_key    = r_key;
        w_valid  = 1'b0;
        w_held   = r_held;
`ifdef BASYS3_KEYPAD_RELEASE_EN
        w_release = 1'b0;
`endif
        case (r_state)
            ST_SCAN: begin
                if (r_settle >= SETTLE_LAST) begin
                    if (w_rows != 4'hF) begin
                        w_row   = lowest_low(w_rows);
                        w_deb   = '0;
                        w_state = ST_DEBOUNCE;
                    end else begin
                        w_col    = r_col + 2'd1;
                        w_settle = '0;
                    end
                end else begin
                    w_settle = r_settle + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (w_row_low) begin
                    if (r_deb >= DEB_LAST) begin
                        w_key   = key_lookup(r_row, r_col);
                        w_valid = 1'b1;
                        w_held  = 1'b1;
                        w_state = ST_HELD;
                    end else if (r_deb != DEB_MAX) begin
                        w_deb = r_deb + 1'b1;
                    end
                end else begin
                    w_state  = ST_SCAN;
                    w_col    = r_col + 2'd1;
                    w_settle = '0;
                end
            end
            ST_HELD: begin
                if (!w_row_low) begin
                    w_deb   = '0;
                    w_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_row_low) begin
                    w_deb   = '0;
                    w_state = ST_HELD;
                end else if (r_deb >= DEB_LAST) begin
                    w_held   = 1'b0;
`ifdef BASYS3_KEYPAD_RELEASE_EN
                    w_release = 1'b1;
`endif
                    w_state  = ST_SCAN;
                    w_col    = r_col + 2'd1;
                    w_settle = '0;
                end else if (r_deb != DEB_MAX) begin
                    w_deb = r_deb + 1'b1;
                end
            end
            default: begin
                w_state = ST_SCAN;
            end
        endcase
    end

    assign col_no      = ~(4'b0001 << r_col);
    assign key_o       = r_key;
    assign key_valid_o = r_valid;
    assign key_held_o  = r_held;
`ifdef BASYS3_KEYPAD_RELEASE_EN
    assign key_release_o = r_release;
`else
    assign key_release_o = 1'b0;
`endif

endmodule

// File: tb/tb_basys3_keypad_scanner.sv
// tb_basys3_keypad_scanner
//   Drives a modelled 4x4 key matrix (a pressed key pulls its row low while
//   its column is driven) and checks scan order, press/release timing, key
//   codes, bounce rejection, key isolation and reset abort.
module tb_basys3_keypad_scanner;

    localparam int S = 4;
    localparam int D = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       valid;
    logic       held;
    logic       rel;
    logic [15:0] press = '0;   // bit r*4+c = key at row r, column c

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;             // index of last rising edge since reset release

    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

`ifdef BASYS3_KEYPAD_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    basys3_keypad_scanner #(
        .SETTLE_CYCLES   (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_1k_i      (clk),
        .rst_i         (rst),
        .row_ni        (row_n),
        .col_no        (col_n),
        .key_o         (key),
        .key_valid_o   (valid),
        .key_held_o    (held),
        .key_release_o (rel)
    );

    function automatic logic [3:0] colmask(input int c);
        logic [3:0] one;
        one = 4'b0001 << c;
        return ~one;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        press = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 5;
        if (col_n !== 4'b1110) begin n_err++; $display("FAIL reset_col got=%b exp=1110", col_n); end
        if (key !== 4'h0)      begin n_err++; $display("FAIL reset_key got=%h exp=0", key); end
        if (valid !== 1'b0)    begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
        if (held !== 1'b0)     begin n_err++; $display("FAIL reset_held got=%b exp=0", held); end
        if (rel !== 1'b0)      begin n_err++; $display("FAIL reset_rel got=%b exp=0", rel); end
    endtask

    task automatic test_scan_idle();
        logic [3:0] exp;
        press = '0;
        do_reset();
        while (cyc < 40) begin
            exp = colmask(((cyc + 1) / S) % 4);
            n_vec += 2;
            if (col_n !== exp) begin n_err++; $display("FAIL idle_col cyc=%0d got=%b exp=%b", cyc, col_n, exp); end
            if (valid !== 1'b0) begin n_err++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", cyc, valid); end
            step();
        end
    endtask

    // Press (r,c) from reset and hold it; sampling of column c happens at
    // the end of its slot, then D debounce cycles precede the pulse.
    task automatic test_press(input int r, input int c, input int extra);
        int k0, e, ec;
        logic [3:0] ek;
        press = '0;
        press[r*4+c] = 1'b1;
        do_reset();
        k0 = c*S + S - 1;
        e  = k0 + D;
        while (cyc <= e + extra) begin
            step();
            ec = (cyc >= k0) ? c : ((cyc + 1) / S) % 4;
            ek = (cyc >= e) ? 4'(keymap[r][c]) : 4'h0;
            n_vec += 4;
            if (valid !== (cyc == e)) begin n_err++; $display("FAIL press_valid r=%0d c=%0d cyc=%0d got=%b exp=%b", r, c, cyc, valid, cyc == e); end
            if (held !== (cyc >= e))  begin n_err++; $display("FAIL press_held r=%0d c=%0d cyc=%0d got=%b exp=%b", r, c, cyc, held, cyc >= e); end
            if (key !== ek)           begin n_err++; $display("FAIL press_key r=%0d c=%0d cyc=%0d got=%h exp=%h", r, c, cyc, key, ek); end
            if (col_n !== colmask(ec)) begin n_err++; $display("FAIL press_col r=%0d c=%0d cyc=%0d got=%b exp=%b", r, c, cyc, col_n, colmask(ec)); end
        end
    endtask

    // Release the key held by test_press, optionally with a short bounce
    // that must not count towards the release debounce.
    task automatic test_release(input int r, input int c, input bit bounce);
        int kr, rr, ec;
        if (bounce) begin
            press[r*4+c] = 1'b0;
            repeat (8) begin
                step();
                n_vec += 2;
                if (held !== 1'b1) begin n_err++; $display("FAIL relb_held cyc=%0d got=%b exp=1", cyc, held); end
                if (rel !== 1'b0)  begin n_err++; $display("FAIL relb_rel cyc=%0d got=%b exp=0", cyc, rel); end
            end
            press[r*4+c] = 1'b1;
            repeat (5) step();
        end
        press[r*4+c] = 1'b0;
        kr = cyc;
        rr = kr + 3 + D;   // 2 sync flops + 1 cycle to notice, then D high samples
        while (cyc < rr + 12) begin
            step();
            ec = (cyc < rr) ? c : (c + 1 + (cyc - rr) / S) % 4;
            n_vec += 4;
            if (rel !== (REL_EN && cyc == rr)) begin n_err++; $display("FAIL rel_pulse c=%0d cyc=%0d got=%b exp=%b", c, cyc, rel, REL_EN && cyc == rr); end
            if (held !== (cyc < rr))  begin n_err++; $display("FAIL rel_held cyc=%0d got=%b exp=%b", cyc, held, cyc < rr); end
            if (valid !== 1'b0)       begin n_err++; $display("FAIL rel_valid cyc=%0d got=%b exp=0", cyc, valid); end
            if (col_n !== colmask(ec)) begin n_err++; $display("FAIL rel_col c=%0d cyc=%0d got=%b exp=%b", c, cyc, col_n, colmask(ec)); end
        end
    endtask

    task automatic test_bounce();
        int b, npulse, klast;
        b = $urandom_range(4, 16);
        npulse = 0;
        klast = -1;
        press = '0;
        press[0] = 1'b1;
        do_reset();
        while (cyc < 150) begin
            step();
            if (cyc == b) press[0] = 1'b0;
            if (cyc == b + 1) press[0] = 1'b1;
            if (cyc <= S + D + 2) begin
                n_vec++;
                if (valid !== 1'b0) begin n_err++; $display("FAIL bounce_early cyc=%0d got=%b exp=0", cyc, valid); end
            end
            if (valid === 1'b1) begin
                npulse++;
                klast = int'(key);
            end
        end
        n_vec += 2;
        if (npulse != 1)             begin n_err++; $display("FAIL bounce_pulses got=%0d exp=1", npulse); end
        if (klast != keymap[0][0])   begin n_err++; $display("FAIL bounce_key got=%0d exp=%0d", klast, keymap[0][0]); end
    endtask

    task automatic test_multi_row();
        int e;
        press = '0;
        press[2*4+3] = 1'b1;
        press[3*4+3] = 1'b1;
        do_reset();
        e = 3*S + S - 1 + D;
        while (cyc < e) begin
            step();
            n_vec++;
            if (valid !== (cyc == e)) begin n_err++; $display("FAIL multi_valid cyc=%0d got=%b exp=%b", cyc, valid, cyc == e); end
        end
        n_vec++;
        if (key !== 4'hC) begin n_err++; $display("FAIL multi_key got=%h exp=c", key); end
        press[0]     = 1'b1;   // (0,0)
        press[1*4+0] = 1'b1;   // (1,0)
        press[0*4+3] = 1'b1;   // (0,3) on the held column, other row
        repeat (60) begin
            step();
            n_vec += 4;
            if (valid !== 1'b0)          begin n_err++; $display("FAIL ignore_valid cyc=%0d got=%b exp=0", cyc, valid); end
            if (held !== 1'b1)           begin n_err++; $display("FAIL ignore_held cyc=%0d got=%b exp=1", cyc, held); end
            if (key !== 4'hC)            begin n_err++; $display("FAIL ignore_key cyc=%0d got=%h exp=c", cyc, key); end
            if (col_n !== colmask(3))    begin n_err++; $display("FAIL ignore_col cyc=%0d got=%b exp=0111", cyc, col_n); end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        press = '0;
        press[0] = 1'b1;
        do_reset();
        while (cyc < S - 1 + 15) begin   // debounce count reaches 15
            step();
            n_vec++;
            if (valid !== 1'b0) begin n_err++; $display("FAIL mid_early cyc=%0d got=%b exp=0", cyc, valid); end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec += 5;
        if (col_n !== 4'b1110) begin n_err++; $display("FAIL mid_col got=%b exp=1110", col_n); end
        if (key !== 4'h0)      begin n_err++; $display("FAIL mid_key got=%h exp=0", key); end
        if (valid !== 1'b0)    begin n_err++; $display("FAIL mid_valid got=%b exp=0", valid); end
        if (held !== 1'b0)     begin n_err++; $display("FAIL mid_held got=%b exp=0", held); end
        if (rel !== 1'b0)      begin n_err++; $display("FAIL mid_rel got=%b exp=0", rel); end
        rst = 1'b0;
        cyc = -1;
        e = S - 1 + D;
        while (cyc < e + 5) begin
            step();
            n_vec++;
            if (valid !== (cyc == e)) begin n_err++; $display("FAIL mid_reaccept cyc=%0d got=%b exp=%b", cyc, valid, cyc == e); end
        end
        n_vec++;
        if (key !== 4'h1) begin n_err++; $display("FAIL mid_key_after got=%h exp=1", key); end
    endtask

    initial begin
        int r, c;
        test_reset();
        test_scan_idle();
        test_press(1, 2, 30);
        test_release(1, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            test_press(r, c, int'($urandom_range(0, 10)));
            test_release(r, c, 1'($urandom_range(0, 1)));
        end
        test_bounce();
        test_multi_row();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
